ctrl: RTL and testbench
=======================

# ctrl

Main control unit of the single-issue RV32I core. It decodes the 5-bit major opcode (instruction bits [6:2]), func3, func7 and the branch-compare result. From these it drives every datapath select: immediate type, ALU operands and operation, write-back source, register write enable, PC source, memory address source, compare op, load/store width, and instruction-path select. It holds the two-phase load sequencer and the NOP-injection flag.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  5  instruction bits [6:2].
- func3  in  3  instruction bits [14:12].
- func7  in  7  instruction bits [31:25].
- b  in  1  branch condition true (from comparator).
- imm_type  out  3  000 none, 001 U, 010 J, 011 S, 100 I, 101 B.
- alu1_sel  out  1  0 rs1, 1 PC.
- alu2_sel  out  1  0 rs2, 1 immediate.
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- rd_sel  out  2  00 immediate, 01 PC+4, 10 ALU result, 11 memory data.
- reg_wr  out  1  register-file write enable.
- pc_sel  out  2  00 ALU result (jump target), 01 PC+4, 10 hold PC.
- mem_sel  out  2  00 PC (fetch), 01 ALU result (data address).
- cmp_op  out  3  000 EQ, 001 NE, 010 LT, 011 GE, 100 LTU, 101 GEU.
- sel_type  out  3  000 byte, 001 half, 010 word, 011 byte-unsigned, 100 half-unsigned.
- inst_sel  out  2  00 memory instruction, 01 NOP (0x00000013), 10 held instruction.

## Operation
- Opcodes: OP 01100, OP_IMM 00100, LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011, JALR 11001, LUI 01101, AUIPC 00101.
- imm_type: LUI, AUIPC → 001; JAL → 010; STORE → 011; OP_IMM, LOAD, JALR → 100; BRANCH → 101; other opcodes → 000.
- alu1_sel = 1 for JAL, BRANCH, AUIPC; 0 otherwise.
- alu2_sel = 0 only for OP; 1 otherwise, including unknown opcodes.
- alu_op is decoded from func3 for OP and OP_IMM:
  - func3 000: SUB only when opcode is OP and func7 = 0100000; ADD otherwise.
  - func3 101: SRA when func7 = 0100000; SRL otherwise.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - All other opcodes use ADD.
- rd_sel: LUI → 00; JAL, JALR → 01; LOAD → 11; all others → 10.
- reg_wr: 1 for OP, OP_IMM, LUI, AUIPC, JAL, JALR; LOAD → load_phase; STORE, BRANCH and unknown opcodes → 0.
- load_phase register:
  - Toggles on every clock while opcode = LOAD.
  - Forced to 0 when opcode ≠ LOAD.
  - Effect: a LOAD occupies two cycles, phase 0 (address) then phase 1 (write-back).
- pc_sel:
  - JAL, JALR → 00.
  - BRANCH: b = 1 → 00; b = 0 → 01.
  - LOAD: load_phase 0 → 10; load_phase 1 → 01.
  - All others → 01.
- mem_sel: STORE → 01; LOAD with load_phase 0 → 01; all other cases → 00.
- cmp_op, from func3 (any opcode): 000→000, 001→001, 100→010, 101→011, 110→100, 111→101, 010/011→000.
- sel_type, from func3 (any opcode): 000→000, 001→001, 010→010, 100→011, 101→100, other→010.
- next_nop register: set to 1 on a clock when opcode is STORE, JAL or JALR, or BRANCH with b = 1; set to 0 on all other clocks.
- inst_sel priority:
  1. next_nop = 1 → 01.
  2. Else LOAD with load_phase 0 → 10.
  3. Else → 00.

## Timing
- All outputs are combinational from the inputs and the two state bits (load_phase, next_nop); zero latency.
- rst low asynchronously clears load_phase and next_nop; both stay 0 while rst is low. While in reset, combinational outputs follow the inputs with both state bits at 0.
- Reset asserted mid-LOAD aborts the sequence. After release, the LOAD restarts in phase 0.
- An opcode change mid-LOAD clears load_phase on the next edge.
- next_nop lasts exactly one cycle per triggering instruction. Consecutive triggers keep it at 1.

## Configuration
- CTRL_AUIPC_EN defined: AUIPC is decoded as in Operation.
- CTRL_AUIPC_EN undefined: AUIPC is treated as an unknown opcode, producing imm_type 000, alu1_sel 0, alu2_sel 1, rd_sel 10, reg_wr 0, pc_sel 01, mem_sel 00.

## Test plan
- Opcode sweep: LUI → imm_type 001; OP_IMM → 100, alu2_sel 1, rd_sel 10, reg_wr 1; STORE → 011, reg_wr 0, mem_sel 01; OP → alu2_sel 0; opcode 10101 → alu2_sel 1, reg_wr 0.
- JAL → alu1_sel 1, rd_sel 01, pc_sel 00, then inst_sel 01 on the next cycle. BRANCH b = 0 → pc_sel 01; b = 1 → pc_sel 00.
- LOAD held 2 cycles after reset:
  - Cycle 0: pc_sel 10, mem_sel 01, reg_wr 0, inst_sel 10.
  - Cycle 1: pc_sel 01, mem_sel 00, reg_wr 1, inst_sel 00.
  - Then repeats.
- func3 110/101/000 → cmp_op 100/011/000. func3 101/100/001 → sel_type 100/011/001.
- OP with func3 000, func7 0100000 → alu_op SUB. OP_IMM with the same fields → ADD. func3 101, func7 0100000 → SRA.
- rst pulsed low during LOAD phase 1 → load_phase and next_nop clear immediately (asynchronously); pc_sel returns to 10.

Source files
------------

// File: rtl/ctrl.sv
// ctrl: main control decoder for the single-issue RV32I core.
// Decodes opcode/func3/func7/branch result into datapath selects, and holds
// the two-phase load sequencer bit and the NOP-injection flag.
// Optional feature macro: CTRL_AUIPC_EN (when undefined, AUIPC decodes as unknown).
module ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       b,
  output logic [2:0] imm_type,
  output logic       alu1_sel,
  output logic       alu2_sel,
  output logic [3:0] alu_op,
  output logic [1:0] rd_sel,
  output logic       reg_wr,
  output logic [1:0] pc_sel,
  output logic [1:0] mem_sel,
  output logic [2:0] cmp_op,
  output logic [2:0] sel_type,
  output logic [1:0] inst_sel
);

  localparam int unsigned OPC_W = 5;
  localparam int unsigned ALU_W = 4;

  localparam logic [OPC_W-1:0] OPC_OP     = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
`ifdef CTRL_AUIPC_EN
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;
`endif

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd9;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic load_phase;
  logic next_nop;
  logic is_load;
  logic nop_trigger;
  logic [ALU_W-1:0] arith_op;

  assign is_load     = (opcode == OPC_LOAD);
  assign nop_trigger = (opcode == OPC_STORE) || (opcode == OPC_JAL) ||
                       (opcode == OPC_JALR) || ((opcode == OPC_BRANCH) && b);

  // Load sequencer phase and one-cycle NOP-injection flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_phase <= 1'b0;
      next_nop   <= 1'b0;
    end else begin
      load_phase <= is_load ? ~load_phase : 1'b0;
      next_nop   <= nop_trigger;
    end
  end

  // Arithmetic op from func3/func7; SUB only for register-register form.
  always_comb begin
    arith_op = ALU_ADD;
    unique case (func3)
      3'b000: arith_op = ((opcode == OPC_OP) && (func7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = (func7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      3'b111: arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  // Opcode decode of the datapath selects; defaults describe an unknown opcode.
  always_comb begin
    imm_type = 3'b000;
    alu1_sel = 1'b0;
    alu2_sel = 1'b1;
    alu_op   = ALU_ADD;
    rd_sel   = 2'b10;
    reg_wr   = 1'b0;
    pc_sel   = 2'b01;
    mem_sel  = 2'b00;
    case (opcode)
      OPC_OP: begin
        alu2_sel = 1'b0;
        alu_op   = arith_op;
        reg_wr   = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_type = 3'b100;
        alu_op   = arith_op;
        reg_wr   = 1'b1;
      end
      OPC_LOAD: begin
        imm_type = 3'b100;
        rd_sel   = 2'b11;
        reg_wr   = load_phase;
        pc_sel   = load_phase ? 2'b01 : 2'b10;
        mem_sel  = load_phase ? 2'b00 : 2'b01;
      end
      OPC_STORE: begin
        imm_type = 3'b011;
        mem_sel  = 2'b01;
      end
      OPC_BRANCH: begin
        imm_type = 3'b101;
        alu1_sel = 1'b1;
        pc_sel   = b ? 2'b00 : 2'b01;
      end
      OPC_JAL: begin
        imm_type = 3'b010;
        alu1_sel = 1'b1;
        rd_sel   = 2'b01;
        reg_wr   = 1'b1;
        pc_sel   = 2'b00;
      end
      OPC_JALR: begin
        imm_type = 3'b100;
        rd_sel   = 2'b01;
        reg_wr   = 1'b1;
        pc_sel   = 2'b00;
      end
      OPC_LUI: begin
        imm_type = 3'b001;
        rd_sel   = 2'b00;
        reg_wr   = 1'b1;
      end
`ifdef CTRL_AUIPC_EN
      OPC_AUIPC: begin
        imm_type = 3'b001;
        alu1_sel = 1'b1;
        reg_wr   = 1'b1;
      end
`endif
      default: begin
        imm_type = 3'b000;
      end
    endcase
  end

  // Comparator op and load/store width, straight from func3.
  always_comb begin
    cmp_op   = 3'b000;
    sel_type = 3'b010;
    case (func3)
      3'b000: begin cmp_op = 3'b000; sel_type = 3'b000; end
      3'b001: begin cmp_op = 3'b001; sel_type = 3'b001; end
      3'b010: begin cmp_op = 3'b000; sel_type = 3'b010; end
      3'b011: begin cmp_op = 3'b000; sel_type = 3'b010; end
      3'b100: begin cmp_op = 3'b010; sel_type = 3'b011; end
      3'b101: begin cmp_op = 3'b011; sel_type = 3'b100; end
      3'b110: begin cmp_op = 3'b100; sel_type = 3'b010; end
      3'b111: begin cmp_op = 3'b101; sel_type = 3'b010; end
      default: begin cmp_op = 3'b000; sel_type = 3'b010; end
    endcase
  end

  // Instruction-path select: injected NOP wins over holding during load phase 0.
  always_comb begin
    inst_sel = 2'b00;
    if (next_nop) begin
      inst_sel = 2'b01;
    end else if (is_load && !load_phase) begin
      inst_sel = 2'b10;
    end
  end

endmodule

// File: tb/tb_ctrl.sv
// tb_ctrl: scoreboard bench for the ctrl decoder.
module tb_ctrl;

  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] LUI    = 5'b01101;
  localparam logic [4:0] AUIPC  = 5'b00101;
  localparam logic [4:0] UNK    = 5'b10101;

  // Field masks in the packed observation vector.
  localparam logic [23:0] M_IMM  = 24'hE00000;
  localparam logic [23:0] M_A1   = 24'h100000;
  localparam logic [23:0] M_A2   = 24'h080000;
  localparam logic [23:0] M_ALU  = 24'h078000;
  localparam logic [23:0] M_RD   = 24'h006000;
  localparam logic [23:0] M_WR   = 24'h001000;
  localparam logic [23:0] M_PC   = 24'h000C00;
  localparam logic [23:0] M_MEM  = 24'h000300;
  localparam logic [23:0] M_CMP  = 24'h0000E0;
  localparam logic [23:0] M_SEL  = 24'h00001C;
  localparam logic [23:0] M_INST = 24'h000003;

  logic       clk;
  logic       rst;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       b;
  logic [2:0] imm_type;
  logic       alu1_sel;
  logic       alu2_sel;
  logic [3:0] alu_op;
  logic [1:0] rd_sel;
  logic       reg_wr;
  logic [1:0] pc_sel;
  logic [1:0] mem_sel;
  logic [2:0] cmp_op;
  logic [2:0] sel_type;
  logic [1:0] inst_sel;
  logic [23:0] obs;

  typedef struct {
    string       name;
    int          step;
    logic [23:0] mask;
    logic [23:0] exp;
  } chk_t;

  chk_t        sb[$];
  logic [23:0] obs_log[$];
  int          n_total;
  int          n_pass;

  ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
    .imm_type(imm_type), .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .alu_op(alu_op),
    .rd_sel(rd_sel), .reg_wr(reg_wr), .pc_sel(pc_sel), .mem_sel(mem_sel),
    .cmp_op(cmp_op), .sel_type(sel_type), .inst_sel(inst_sel)
  );

  assign obs = {imm_type, alu1_sel, alu2_sel, alu_op, rd_sel, reg_wr,
                pc_sel, mem_sel, cmp_op, sel_type, inst_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] fld(input logic [23:0] m, input logic [23:0] v);
    int s;
    s = 0;
    for (int i = 23; i >= 0; i--) if (m[i]) s = i;
    return (v << s) & m;
  endfunction

  // Queue an expected field value against the next sample.
  task automatic expect_f(input string name, input logic [23:0] m, input logic [23:0] v);
    chk_t e;
    e.name = name;
    e.step = obs_log.size();
    e.mask = m;
    e.exp  = fld(m, v);
    sb.push_back(e);
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic bb);
    @(negedge clk);
    opcode = op; func3 = f3; func7 = f7; b = bb;
  endtask

  // Record DUT outputs, settled and clear of the rising edge.
  task automatic sample();
    #2;
    obs_log.push_back(obs);
  endtask

  task automatic test_reset();
    chk_t e;
    rst = 1'b0;
    opcode = LOAD; func3 = 3'b000; func7 = 7'd0; b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_f("rst_load_pc", M_PC, 2);
    expect_f("rst_load_inst", M_INST, 2);
    expect_f("rst_load_wr", M_WR, 0);
    expect_f("rst_load_mem", M_MEM, 1);
    sample();
    @(posedge clk);
    @(negedge clk);
    expect_f("rst_hold_pc", M_PC, 2);
    sample();
    opcode = OP_IMM;
    #1 rst = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      if ((obs_log[e.step] & e.mask) !== e.exp)
        $display("FAIL %s: got %06h want %06h (mask %06h)", e.name, obs_log[e.step] & e.mask, e.exp, e.mask);
      else n_pass++;
    end
  endtask

  task automatic test_opcode_sweep();
    chk_t e;
    drive(LUI, 3'b000, 7'd0, 1'b0);
    expect_f("lui_imm", M_IMM, 1);
    expect_f("lui_rd", M_RD, 0);
    expect_f("lui_wr", M_WR, 1);
    expect_f("lui_inst", M_INST, 0);
    sample();
    drive(OP_IMM, 3'b000, 7'd0, 1'b0);
    expect_f("opimm_imm", M_IMM, 4);
    expect_f("opimm_a2", M_A2, 1);
    expect_f("opimm_rd", M_RD, 2);
    expect_f("opimm_wr", M_WR, 1);
    expect_f("opimm_alu", M_ALU, 0);
    sample();
    drive(STORE, 3'b010, 7'd0, 1'b0);
    expect_f("store_imm", M_IMM, 3);
    expect_f("store_wr", M_WR, 0);
    expect_f("store_mem", M_MEM, 1);
    expect_f("store_pc", M_PC, 1);
    sample();
    drive(OP, 3'b000, 7'd0, 1'b0);
    expect_f("op_a2", M_A2, 0);
    expect_f("op_after_store_inst", M_INST, 1);
    sample();
    drive(UNK, 3'b000, 7'd0, 1'b0);
    expect_f("unk_a2", M_A2, 1);
    expect_f("unk_wr", M_WR, 0);
    expect_f("unk_imm", M_IMM, 0);
    expect_f("unk_inst", M_INST, 0);
    sample();
    drive(AUIPC, 3'b000, 7'd0, 1'b0);
`ifdef CTRL_AUIPC_EN
    expect_f("auipc_imm", M_IMM, 1);
    expect_f("auipc_a1", M_A1, 1);
    expect_f("auipc_wr", M_WR, 1);
`else
    expect_f("auipc_imm", M_IMM, 0);
    expect_f("auipc_a1", M_A1, 0);
    expect_f("auipc_wr", M_WR, 0);
`endif
    expect_f("auipc_a2", M_A2, 1);
    expect_f("auipc_rd", M_RD, 2);
    expect_f("auipc_pc", M_PC, 1);
    expect_f("auipc_mem", M_MEM, 0);
    sample();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      if ((obs_log[e.step] & e.mask) !== e.exp)
        $display("FAIL %s: got %06h want %06h (mask %06h)", e.name, obs_log[e.step] & e.mask, e.exp, e.mask);
      else n_pass++;
    end
  endtask

  task automatic test_jump_branch();
    chk_t e;
    drive(JAL, 3'b000, 7'd0, 1'b0);
    expect_f("jal_a1", M_A1, 1);
    expect_f("jal_rd", M_RD, 1);
    expect_f("jal_pc", M_PC, 0);
    expect_f("jal_imm", M_IMM, 2);
    expect_f("jal_wr", M_WR, 1);
    sample();
    drive(OP, 3'b000, 7'd0, 1'b0);
    expect_f("after_jal_inst", M_INST, 1);
    sample();
    drive(OP, 3'b000, 7'd0, 1'b0);
    expect_f("nop_one_cycle_inst", M_INST, 0);
    sample();
    drive(BRANCH, 3'b110, 7'd0, 1'b0);
    expect_f("br_nt_pc", M_PC, 1);
    expect_f("br_nt_imm", M_IMM, 5);
    expect_f("br_nt_a1", M_A1, 1);
    expect_f("br_nt_wr", M_WR, 0);
    expect_f("br_nt_cmp", M_CMP, 4);
    sample();
    drive(BRANCH, 3'b000, 7'd0, 1'b1);
    expect_f("br_t_pc", M_PC, 0);
    expect_f("br_after_nt_inst", M_INST, 0);
    sample();
    drive(JALR, 3'b000, 7'd0, 1'b0);
    expect_f("jalr_pc", M_PC, 0);
    expect_f("jalr_rd", M_RD, 1);
    expect_f("jalr_imm", M_IMM, 4);
    expect_f("after_br_t_inst", M_INST, 1);
    sample();
    drive(OP, 3'b000, 7'd0, 1'b0);
    expect_f("after_jalr_inst", M_INST, 1);
    sample();
    drive(OP, 3'b000, 7'd0, 1'b0);
    expect_f("nop_clear_inst", M_INST, 0);
    sample();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      if ((obs_log[e.step] & e.mask) !== e.exp)
        $display("FAIL %s: got %06h want %06h (mask %06h)", e.name, obs_log[e.step] & e.mask, e.exp, e.mask);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    chk_t e;
    drive(OP, 3'b000, 7'd0, 1'b0);
    sample();
    for (int k = 0; k < 4; k++) begin
      drive(LOAD, 3'b010, 7'd0, 1'b0);
      if (k % 2 == 0) begin
        expect_f($sformatf("ld%0d_pc", k), M_PC, 2);
        expect_f($sformatf("ld%0d_mem", k), M_MEM, 1);
        expect_f($sformatf("ld%0d_wr", k), M_WR, 0);
        expect_f($sformatf("ld%0d_inst", k), M_INST, 2);
      end else begin
        expect_f($sformatf("ld%0d_pc", k), M_PC, 1);
        expect_f($sformatf("ld%0d_mem", k), M_MEM, 0);
        expect_f($sformatf("ld%0d_wr", k), M_WR, 1);
        expect_f($sformatf("ld%0d_inst", k), M_INST, 0);
      end
      expect_f($sformatf("ld%0d_rd", k), M_RD, 3);
      sample();
    end
    drive(LOAD, 3'b010, 7'd0, 1'b0);
    expect_f("ld_abort_p0_pc", M_PC, 2);
    sample();
    drive(OP, 3'b000, 7'd0, 1'b0);
    expect_f("ld_abort_op_inst", M_INST, 0);
    sample();
    drive(LOAD, 3'b010, 7'd0, 1'b0);
    expect_f("ld_restart_pc", M_PC, 2);
    expect_f("ld_restart_inst", M_INST, 2);
    sample();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      if ((obs_log[e.step] & e.mask) !== e.exp)
        $display("FAIL %s: got %06h want %06h (mask %06h)", e.name, obs_log[e.step] & e.mask, e.exp, e.mask);
      else n_pass++;
    end
  endtask

  task automatic test_func3();
    chk_t e;
    logic [2:0] cmp_t [8];
    logic [2:0] sel_t [8];
    logic [3:0] alu_t [8];
    cmp_t = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
    sel_t = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd2, 3'd2};
    alu_t = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    for (int f = 0; f < 8; f++) begin
      drive(OP, 3'(f), 7'd0, 1'b0);
      expect_f($sformatf("f3_%0d_cmp", f), M_CMP, 24'(cmp_t[f]));
      expect_f($sformatf("f3_%0d_sel", f), M_SEL, 24'(sel_t[f]));
      expect_f($sformatf("f3_%0d_alu", f), M_ALU, 24'(alu_t[f]));
      sample();
    end
    drive(OP, 3'b000, 7'b0100000, 1'b0);
    expect_f("op_sub", M_ALU, 1);
    sample();
    drive(OP_IMM, 3'b000, 7'b0100000, 1'b0);
    expect_f("opimm_no_sub", M_ALU, 0);
    sample();
    drive(OP, 3'b101, 7'b0100000, 1'b0);
    expect_f("op_sra", M_ALU, 7);
    sample();
    drive(OP_IMM, 3'b101, 7'b0100000, 1'b0);
    expect_f("opimm_sra", M_ALU, 7);
    sample();
    drive(JAL, 3'b111, 7'b0100000, 1'b0);
    expect_f("jal_alu_add", M_ALU, 0);
    expect_f("jal_cmp_any_op", M_CMP, 5);
    sample();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      if ((obs_log[e.step] & e.mask) !== e.exp)
        $display("FAIL %s: got %06h want %06h (mask %06h)", e.name, obs_log[e.step] & e.mask, e.exp, e.mask);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    chk_t e;
    drive(OP, 3'b000, 7'd0, 1'b0);
    sample();
    drive(LOAD, 3'b000, 7'd0, 1'b0);
    expect_f("mid_p0_pc", M_PC, 2);
    sample();
    drive(LOAD, 3'b000, 7'd0, 1'b0);
    expect_f("mid_p1_pc", M_PC, 1);
    expect_f("mid_p1_wr", M_WR, 1);
    sample();
    rst = 1'b0;
    #1;
    expect_f("async_rst_pc", M_PC, 2);
    expect_f("async_rst_inst", M_INST, 2);
    expect_f("async_rst_wr", M_WR, 0);
    sample();
    @(negedge clk);
    expect_f("in_rst_after_edge_pc", M_PC, 2);
    sample();
    rst = 1'b1;
    #1;
    expect_f("released_p0_pc", M_PC, 2);
    sample();
    drive(LOAD, 3'b000, 7'd0, 1'b0);
    expect_f("released_p1_pc", M_PC, 1);
    sample();
    drive(JAL, 3'b000, 7'd0, 1'b0);
    sample();
    drive(OP, 3'b000, 7'd0, 1'b0);
    expect_f("nop_set_inst", M_INST, 1);
    sample();
    rst = 1'b0;
    #1;
    expect_f("nop_async_clr_inst", M_INST, 0);
    sample();
    #1 rst = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      if ((obs_log[e.step] & e.mask) !== e.exp)
        $display("FAIL %s: got %06h want %06h (mask %06h)", e.name, obs_log[e.step] & e.mask, e.exp, e.mask);
      else n_pass++;
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_opcode_sweep();
    test_jump_branch();
    test_load();
    test_func3();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
